// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: gathers OVL checker fire vectors into saturating
// statistics, a first-failure record and a timestamped event FIFO.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   enable              sampling enable (fire ignored when 0)
//   clear               synchronous clear of statistics and FIFO
//   fire                3 bits per checker: {cover, x_fail, fail}
//   evt_valid/ready     head-of-FIFO handshake
//   evt_chk_id/type/time  head event payload
//   fail_cnt, xfail_cnt, cov_cnt, drop_cnt  saturating counters
//   err_sticky, first_fail_id, first_fail_time  first-failure record
module ovl_fire_collector #(
  parameter int unsigned NUM_CHK    = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [3*NUM_CHK-1:0] fire,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [3:0]           evt_chk_id,
  output logic [1:0]           evt_type,
  output logic [TS_W-1:0]      evt_time,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     xfail_cnt,
  output logic [CNT_W-1:0]     cov_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_sticky,
  output logic [3:0]           first_fail_id,
  output logic [TS_W-1:0]      first_fail_time
);

  localparam int unsigned SUM_W  = CNT_W + 4;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0]      chk_id;
    logic [1:0]      etype;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [TS_W-1:0]       ts_q;
  evt_t                  ent_q [FIFO_DEPTH];
  evt_t                  ent_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [CNT_FW-1:0]     cnt_q, cnt_d;
  logic [CNT_FW-1:0]     wpos;

  logic             sample;
  logic [SUM_W-1:0] pop_fail, pop_xfail, pop_cov, n_ev, drop_add;
  logic             has_ev;
  logic [3:0]       win_id;
  logic [1:0]       win_type;
  logic             pop, push, full, win_drop;

  // Widen, add, clamp so a counter never wraps.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign sample = enable & ~clear;

  // Popcounts and lowest-index event selection; descending scan leaves the lowest winner.
  always_comb begin
    pop_fail  = '0;
    pop_xfail = '0;
    pop_cov   = '0;
    n_ev      = '0;
    has_ev    = 1'b0;
    win_id    = '0;
    win_type  = '0;
    if (sample) begin
      for (int k = NUM_CHK - 1; k >= 0; k--) begin
        pop_fail  = pop_fail  + SUM_W'(fire[3*k]);
        pop_xfail = pop_xfail + SUM_W'(fire[3*k+1]);
        pop_cov   = pop_cov   + SUM_W'(fire[3*k+2]);
        if (fire[3*k] | fire[3*k+1]) begin
          n_ev     = n_ev + SUM_W'(1);
          has_ev   = 1'b1;
          win_id   = 4'(k);
          win_type = fire[3*k+1] ? 2'd1 : 2'd0;
        end
      end
    end
  end

  assign pop      = vld_q[0] & evt_ready;
  assign full     = vld_q[FIFO_DEPTH-1];
  assign push     = has_ev & (~full | pop);
  assign win_drop = has_ev & full & ~pop;
  // Losers of arbitration plus a winner rejected by a full FIFO.
  assign drop_add = (has_ev ? (n_ev - SUM_W'(1)) : '0) + SUM_W'(win_drop);

  // Shift-register FIFO: entry 0 is always the head, so evt_* come straight from flops.
  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    wpos  = cnt_q - CNT_FW'(pop);
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        ent_d[i] = ent_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      ent_d[wpos[PTR_W-1:0]] = '{chk_id: win_id, etype: win_type, ts: ts_q};
      vld_d[wpos[PTR_W-1:0]] = 1'b1;
    end
    cnt_d = cnt_q - CNT_FW'(pop) + CNT_FW'(push);
    if (clear) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  // Timestamp runs independently of enable and clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  // FIFO storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) ent_q[i] <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) ent_q[i] <= ent_d[i];
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Statistics and first-failure record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail_cnt        <= '0;
      xfail_cnt       <= '0;
      cov_cnt         <= '0;
      drop_cnt        <= '0;
      err_sticky      <= 1'b0;
      first_fail_id   <= '0;
      first_fail_time <= '0;
    end else if (clear) begin
      fail_cnt        <= '0;
      xfail_cnt       <= '0;
      cov_cnt         <= '0;
      drop_cnt        <= '0;
      err_sticky      <= 1'b0;
      first_fail_id   <= '0;
      first_fail_time <= '0;
    end else begin
      fail_cnt  <= sat_add(fail_cnt, pop_fail);
      xfail_cnt <= sat_add(xfail_cnt, pop_xfail);
      cov_cnt   <= sat_add(cov_cnt, pop_cov);
      drop_cnt  <= sat_add(drop_cnt, drop_add);
      if (has_ev && !err_sticky) begin
        err_sticky      <= 1'b1;
        first_fail_id   <= win_id;
        first_fail_time <= ts_q;
      end
    end
  end

  assign evt_valid  = vld_q[0];
  assign evt_chk_id = ent_q[0].chk_id;
  assign evt_type   = ent_q[0].etype;
  assign evt_time   = ent_q[0].ts;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector: vector table plus hand sequences for
// backpressure, clear, saturation (second instance with 4-bit counters) and async reset.
module tb_ovl_fire_collector;

  logic        clock, reset, enable, clear, evt_ready;
  logic [11:0] fire;
  logic        evt_valid, err_sticky;
  logic [3:0]  evt_chk_id, first_fail_id;
  logic [1:0]  evt_type;
  logic [31:0] evt_time, first_fail_time;
  logic [15:0] fail_cnt, xfail_cnt, cov_cnt, drop_cnt;

  logic        s_valid, s_err;
  logic [3:0]  s_id, s_ffid;
  logic [1:0]  s_type;
  logic [31:0] s_time, s_fft;
  logic [3:0]  s_fail, s_xfail, s_cov, s_drop;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc;
  int unsigned t_last;

  ovl_fire_collector #(.NUM_CHK(4), .CNT_W(16), .TS_W(32), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .fire(fire),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chk_id(evt_chk_id),
    .evt_type(evt_type), .evt_time(evt_time), .fail_cnt(fail_cnt),
    .xfail_cnt(xfail_cnt), .cov_cnt(cov_cnt), .drop_cnt(drop_cnt),
    .err_sticky(err_sticky), .first_fail_id(first_fail_id),
    .first_fail_time(first_fail_time));

  ovl_fire_collector #(.NUM_CHK(4), .CNT_W(4), .TS_W(32), .FIFO_DEPTH(4)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .fire(fire),
    .evt_valid(s_valid), .evt_ready(evt_ready), .evt_chk_id(s_id),
    .evt_type(s_type), .evt_time(s_time), .fail_cnt(s_fail),
    .xfail_cnt(s_xfail), .cov_cnt(s_cov), .drop_cnt(s_drop),
    .err_sticky(s_err), .first_fail_id(s_ffid),
    .first_fail_time(s_fft));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference cycle counter for expected timestamps.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic [11:0] f, input logic rdy);
    enable    = en;
    clear     = clr;
    fire      = f;
    evt_ready = rdy;
    t_last    = cyc;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        clr;
    logic [11:0] fire;
    logic        rdy;
    int unsigned fail;
    int unsigned xf;
    int unsigned cov;
    int unsigned drop;
    logic        err;
    logic        valid;
    logic [3:0]  id;
    logic [1:0]  typ;
    logic [3:0]  ffid;
  } vec_t;

  vec_t        vecs [12];
  int unsigned tq [6];
  int unsigned exp_t [4];

  initial begin
    // en clr fire rdy | fail xf cov drop err valid id typ ffid
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1, 0, 0, 0, 1'b1, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 12'h618, 1'b1, 3, 2, 0, 1, 1'b1, 1'b1, 4'd1, 2'd1, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 12'h100, 1'b1, 3, 2, 1, 1, 1'b1, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 12'h001, 1'b1, 3, 2, 1, 1, 1'b1, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 12'h002, 1'b0, 3, 3, 1, 1, 1'b1, 1'b1, 4'd0, 2'd1, 4'd0};
    vecs[5]  = '{1'b1, 1'b0, 12'h000, 1'b0, 3, 3, 1, 1, 1'b1, 1'b1, 4'd0, 2'd1, 4'd0};
    vecs[6]  = '{1'b1, 1'b0, 12'hA00, 1'b1, 4, 3, 2, 1, 1'b1, 1'b1, 4'd3, 2'd0, 4'd0};
    vecs[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 4, 3, 2, 1, 1'b1, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 12'h001, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[9]  = '{1'b1, 1'b0, 12'h004, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 12'h200, 1'b0, 1, 0, 1, 0, 1'b1, 1'b1, 4'd3, 2'd0, 4'd3};
    vecs[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 1, 0, 1, 0, 1'b1, 1'b0, 4'd0, 2'd0, 4'd3};

    reset = 1'b0; enable = 1'b0; clear = 1'b0; fire = '0; evt_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_time", evt_time, 0);
    chk("rst_fft", first_fail_time, 0);
    reset = 1'b1;

    // Single failure at the edge where ts = 5.
    repeat (5) step(1'b1, 1'b0, 12'h000, 1'b0);
    step(1'b1, 1'b0, 12'h001, 1'b0);
    chk("single_fail", fail_cnt, 1);
    chk("single_err", err_sticky, 1);
    chk("single_ffid", first_fail_id, 0);
    chk("single_fft", first_fail_time, 5);
    chk("single_valid", evt_valid, 1);
    chk("single_type", evt_type, 0);
    chk("single_time", evt_time, 5);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].fire, vecs[i].rdy);
      chk($sformatf("v%0d_fail", i), fail_cnt, vecs[i].fail);
      chk($sformatf("v%0d_xfail", i), xfail_cnt, vecs[i].xf);
      chk($sformatf("v%0d_cov", i), cov_cnt, vecs[i].cov);
      chk($sformatf("v%0d_drop", i), drop_cnt, vecs[i].drop);
      chk($sformatf("v%0d_err", i), err_sticky, vecs[i].err);
      chk($sformatf("v%0d_valid", i), evt_valid, vecs[i].valid);
      chk($sformatf("v%0d_ffid", i), first_fail_id, vecs[i].ffid);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_id", i), evt_chk_id, vecs[i].id);
        chk($sformatf("v%0d_type", i), evt_type, vecs[i].typ);
      end
    end

    // Clear beats fire; the next fire records a fresh first failure with an unreset ts.
    step(1'b1, 1'b1, 12'h001, 1'b0);
    chk("clr_fail", fail_cnt, 0);
    chk("clr_err", err_sticky, 0);
    chk("clr_valid", evt_valid, 0);
    chk("clr_fft", first_fail_time, 0);
    step(1'b1, 1'b0, 12'h040, 1'b0);
    chk("clr_next_fft", first_fail_time, t_last);
    chk("clr_next_ffid", first_fail_id, 2);
    chk("clr_next_time", evt_time, t_last);
    step(1'b1, 1'b0, 12'h000, 1'b1);

    // Backpressure: five fails from checker 2 into a 4-deep FIFO.
    step(1'b1, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 12'h040, 1'b0);
      tq[i] = t_last;
    end
    chk("bp_fail", fail_cnt, 5);
    chk("bp_drop", drop_cnt, 1);
    chk("bp_valid", evt_valid, 1);
    chk("bp_id", evt_chk_id, 2);
    chk("bp_head", evt_time, tq[0]);
    // Full FIFO with pop and push together.
    step(1'b1, 1'b0, 12'h040, 1'b1);
    tq[5] = t_last;
    chk("pp_drop", drop_cnt, 1);
    chk("pp_fail", fail_cnt, 6);
    exp_t[0] = tq[1]; exp_t[1] = tq[2]; exp_t[2] = tq[3]; exp_t[3] = tq[5];
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), evt_valid, 1);
      chk($sformatf("drain%0d_time", i), evt_time, exp_t[i]);
      step(1'b1, 1'b0, 12'h000, 1'b1);
    end
    chk("drain_empty", evt_valid, 0);
    chk("drain_drop", drop_cnt, 1);

    // Sustained push/pop and saturation of a 4-bit counter.
    step(1'b1, 1'b1, 12'h000, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 12'h001, 1'b1);
    chk("sat_wide_fail", fail_cnt, 20);
    chk("sat_narrow_fail", s_fail, 15);
    chk("stream_drop", drop_cnt, 0);
    chk("stream_narrow_drop", s_drop, 0);
    chk("stream_valid", evt_valid, 1);
    chk("stream_time", evt_time, t_last);

    // Asynchronous reset with three queued events.
    step(1'b1, 1'b1, 12'h000, 1'b0);
    repeat (3) step(1'b1, 1'b0, 12'h001, 1'b0);
    chk("ar_pre_valid", evt_valid, 1);
    chk("ar_pre_fail", fail_cnt, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", evt_valid, 0);
    chk("ar_fail", fail_cnt, 0);
    chk("ar_err", err_sticky, 0);
    chk("ar_fft", first_fail_time, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 12'h008, 1'b0);
    chk("ar_post_time", evt_time, 0);
    chk("ar_post_id", evt_chk_id, 1);
    chk("ar_post_valid", evt_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
